// File: rtl/toggle_event_decoder_if.sv
// -----------------------------------------------------------------------------
// toggle_event_decoder_if
//
// Purpose: consumer-side handshake bundle of the toggle event decoder.
//
// Signals:
//   evt_valid    high while at least one event is pending
//   evt_pending  number of detected but unacknowledged events (CNT_W bits)
//   evt_ack      consumer takes one pending event this cycle
//
// Modports:
//   master  the decoder (drives valid/pending, receives ack)
//   slave   the consumer (receives valid/pending, drives ack)
// -----------------------------------------------------------------------------
interface toggle_event_decoder_if #(
    parameter int CNT_W = 8
) ();
    logic             evt_valid;
    logic [CNT_W-1:0] evt_pending;
    logic             evt_ack;

    modport master (
        output evt_valid,
        output evt_pending,
        input  evt_ack
    );

    modport slave (
        input  evt_valid,
        input  evt_pending,
        output evt_ack
    );
endinterface

// File: rtl/toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// toggle_event_decoder
//
// Purpose: destination end of a two-phase (toggle) event crossing. The
// asynchronous toggle level is synchronised into clk, every sampled level
// change becomes a one-cycle event pulse, and events are accumulated in a
// saturating pending counter drained by a valid/ack handshake. A wrapping
// total counter and a sticky overflow flag are provided for debug.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on tog_in, legal range 2..4
//   CNT_W        width of the pending and total counters
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous active-low reset
//   tog_in       asynchronous toggle level, each transition is one event
//   clr          synchronous clear of evt_total and overflow
//   evt_if       handshake bundle (master): evt_valid, evt_pending, evt_ack
//   event_pulse  registered one-cycle pulse per detected event
//   evt_total    events since reset/clr, wraps modulo 2^CNT_W
//   overflow     sticky: an event was lost while pending was saturated
//
// Build option:
//   TOG_DEC_GLITCH_FILTER_EN  when defined, a filter register follows the
//   synchroniser; a level is accepted only after it has been seen on two
//   consecutive edges. Event latency and the priming period both grow by one.
// -----------------------------------------------------------------------------
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tog_in,
    input  logic                   clr,
    toggle_event_decoder_if.master evt_if,
    output logic                   event_pulse,
    output logic [CNT_W-1:0]       evt_total,
    output logic                   overflow
);

`ifdef TOG_DEC_GLITCH_FILTER_EN
    localparam int PRIME_LEN = SYNC_STAGES + 2;
`else
    localparam int PRIME_LEN = SYNC_STAGES + 1;
`endif

    localparam logic [2:0]       PRIME_LAST = 3'(PRIME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       prime_cnt_q, prime_cnt_d;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic             sync_out;
    logic             lvl_stable;
    logic             prev_p1;
    logic             evt_p1;
    logic             ack_ok;
    logic [CNT_W-1:0] pending_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // ---- stage p0: synchroniser on the asynchronous toggle level ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], tog_in};
        end
    end

    assign sync_out = sync_p0[SYNC_STAGES-1];

`ifdef TOG_DEC_GLITCH_FILTER_EN
    logic filt_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_p1 <= 1'b0;
        end else begin
            filt_p1 <= sync_out;
        end
    end

    // A level only counts once it has been present on two consecutive edges,
    // so a single-cycle excursion never reaches the change detector.
    assign lvl_stable = (sync_out == filt_p1);
`else
    assign lvl_stable = 1'b1;
`endif

    // ---- stage p1: change detection against the last accepted level ----
    // While priming, prev follows the synchroniser blindly so that whatever
    // level tog_in had at reset release is absorbed without an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_p1 <= 1'b0;
        end else if (state_q == S_PRIME || lvl_stable) begin
            prev_p1 <= sync_out;
        end
    end

    assign evt_p1 = (state_q == S_RUN) && lvl_stable && (sync_out != prev_p1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_PRIME;
            prime_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        case (state_q)
            S_PRIME: begin
                if (prime_cnt_q == PRIME_LAST) begin
                    state_d = S_RUN;
                end else begin
                    prime_cnt_d = prime_cnt_q + 3'd1;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_PRIME;
        endcase
    end

    // ---- stage p2: pulse register and event counters ----
    // An ack while nothing is pending is simply dropped.
    assign ack_ok = evt_if.evt_ack && (pending_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            event_pulse <= 1'b0;
            pending_q   <= '0;
            evt_total   <= '0;
            overflow    <= 1'b0;
        end else begin
            event_pulse <= evt_p1;

            // Event and ack on the same edge cancel out.
            case ({evt_p1, ack_ok})
                2'b10:   pending_q <= sat_inc(pending_q);
                2'b01:   pending_q <= pending_q - CNT_W'(1);
                default: pending_q <= pending_q;
            endcase

            // clr wins over an event landing on the same edge; that event is
            // still reflected in pending.
            if (clr) begin
                evt_total <= '0;
                overflow  <= 1'b0;
            end else begin
                if (evt_p1) begin
                    evt_total <= evt_total + CNT_W'(1);
                end
                if (evt_p1 && !ack_ok && (pending_q == CNT_MAX)) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign evt_if.evt_pending = pending_q;
    assign evt_if.evt_valid   = (pending_q != '0);

endmodule
